// File: rtl/router_pkg.sv
// Shared constants and FSM encoding for the router output-port packet reader.
// Header byte layout: [HDR_LEN_MSB:HDR_LEN_LSB] payload length, [ADDR_W-1:0] destination.
package router_pkg;

  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned MAX_PAYLOAD = 63;
  localparam int unsigned DEF_TIMEOUT = 30;
  localparam int unsigned LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    BODY     = 2'd2
  } rx_state_t;

endpackage

// File: rtl/router_pkt_rx_if.sv
// FIFO-read / payload-sink / status bundle of one router output port.
//   valid_out, data_out : FIFO not-empty and registered read data
//   read_enb            : FIFO read strobe
//   sink_ready          : downstream accepts payload bytes
//   byte_valid/byte_data: payload stream
//   hdr_len, pkt_done, parity_err, addr_err, timeout_err, busy : packet status
// slave = packet reader, master = FIFO/sink side.
interface router_pkt_rx_if #(
  parameter int unsigned WIDTH = 8
);

  logic                         valid_out;
  logic [WIDTH-1:0]             data_out;
  logic                         read_enb;
  logic                         sink_ready;
  logic                         byte_valid;
  logic [WIDTH-1:0]             byte_data;
  logic [router_pkg::LEN_W-1:0] hdr_len;
  logic                         pkt_done;
  logic                         parity_err;
  logic                         addr_err;
  logic                         timeout_err;
  logic                         busy;

  modport slave (
    input  valid_out, data_out, sink_ready,
    output read_enb, byte_valid, byte_data, hdr_len,
           pkt_done, parity_err, addr_err, timeout_err, busy
  );

  modport master (
    output valid_out, data_out, sink_ready,
    input  read_enb, byte_valid, byte_data, hdr_len,
           pkt_done, parity_err, addr_err, timeout_err, busy
  );

endinterface

// File: rtl/router_rx_timeout.sv
// Loadable consecutive-cycle counter with an expire pulse.
//   clock, resetn : clock, async active-low reset
//   clr_i         : zero the count (highest priority)
//   load_i        : preset the count to load_val_i
//   en_i          : count one cycle
//   expire_c      : combinational, high on the enabled cycle that reaches LIMIT
module router_rx_timeout #(
  parameter int unsigned LIMIT = 30
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             clr_i,
  input  logic                             load_i,
  input  logic [$clog2(LIMIT+1)-1:0]       load_val_i,
  input  logic                             en_i,
  output logic                             expire_c
);

  localparam int unsigned TW = $clog2(LIMIT + 1);

  logic [TW-1:0] count_q, count_d;

  // Count saturates at LIMIT so a held enable never wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != TW'(LIMIT))) begin
      count_d = count_q + TW'(1);
    end
  end

  assign expire_c = en_i && !clr_i && !load_i && (count_q == TW'(LIMIT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/router_pkt_rx.sv
// Destination-side packet reader for one router output port: drains the
// output FIFO, reassembles header/payload/parity, streams the payload and
// reports per-packet parity, address and timeout status.
//   clock, resetn : clock, async active-low reset
//   rx            : router_pkt_rx_if.slave (FIFO read, payload sink, status)
//   pkt_cnt, err_cnt : saturating statistics, present only with RX_PKT_STATS_EN
module router_pkt_rx
  import router_pkg::*;
#(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [ADDR_W-1:0]  PORT_ADDR = 2'd0,
  parameter int unsigned        TIMEOUT   = DEF_TIMEOUT
`ifdef RX_PKT_STATS_EN
  , parameter int unsigned      CNT_W     = 16
`endif
) (
  input  logic               clock,
  input  logic               resetn,
  router_pkt_rx_if.slave     rx
`ifdef RX_PKT_STATS_EN
  , output logic [CNT_W-1:0] pkt_cnt
  , output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(MAX_PAYLOAD + 2);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_HDR_WAIT = HDR_WAIT;
  localparam logic [1:0] S_BODY     = BODY;

  logic [1:0]        state_q, state_d;
  logic              cap_q;
  logic              busy_q, busy_d;
  logic [LEN_W-1:0]  hdr_len_q, hdr_len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  remaining_q, remaining_d;
  logic [IDX_W-1:0]  issued_q, issued_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic              byte_valid_q, byte_valid_d;
  logic [WIDTH-1:0]  byte_data_q, byte_data_d;
  logic              pkt_done_q, pkt_done_d;
  logic              parity_err_q, parity_err_d;
  logic              addr_err_q, addr_err_d;
  logic              timeout_err_q, timeout_err_d;

  logic read_enb_c;
  logic rd_issue_c;
  logic tmo_active_c;
  logic tmo_expire_c;

  // FIFO read strobe; gated by resetn so the port is quiet during reset.
  always_comb begin
    read_enb_c = 1'b0;
    case (state_q)
      S_IDLE: read_enb_c = rx.valid_out;
      S_BODY: read_enb_c = rx.valid_out & rx.sink_ready & (issued_q < remaining_q);
      default: read_enb_c = 1'b0;
    endcase
    read_enb_c = read_enb_c & resetn;
  end

  assign rd_issue_c   = read_enb_c & rx.valid_out;
  assign tmo_active_c = (state_q == S_HDR_WAIT) ||
                        ((state_q == S_BODY) && (issued_q < remaining_q));

  router_rx_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clock      (clock),
    .resetn     (resetn),
    .clr_i      (!tmo_active_c || rx.valid_out),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tmo_active_c && !rx.valid_out),
    .expire_c   (tmo_expire_c)
  );

  // Packet reassembly FSM and status generation.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    hdr_len_d     = hdr_len_q;
    addr_d        = addr_q;
    acc_d         = acc_q;
    remaining_d   = remaining_q;
    issued_d      = issued_q;
    rx_idx_d      = rx_idx_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    pkt_done_d    = 1'b0;
    parity_err_d  = parity_err_q;
    addr_err_d    = addr_err_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (rd_issue_c) begin
          state_d = S_HDR_WAIT;
          busy_d  = 1'b1;
        end
      end

      S_HDR_WAIT: begin
        if (cap_q) begin
          hdr_len_d   = rx.data_out[HDR_LEN_MSB:HDR_LEN_LSB];
          addr_d      = rx.data_out[ADDR_W-1:0];
          acc_d       = rx.data_out;
          remaining_d = IDX_W'(rx.data_out[HDR_LEN_MSB:HDR_LEN_LSB]) + IDX_W'(1);
          issued_d    = '0;
          rx_idx_d    = '0;
          state_d     = S_BODY;
        end else if (tmo_expire_c) begin
          pkt_done_d    = 1'b1;
          parity_err_d  = 1'b0;
          addr_err_d    = 1'b0;
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end
      end

      S_BODY: begin
        if (rd_issue_c) begin
          issued_d = issued_q + IDX_W'(1);
        end
        if (cap_q) begin
          if (rx_idx_q < IDX_W'(hdr_len_q)) begin
            byte_valid_d = 1'b1;
            byte_data_d  = rx.data_out;
            acc_d        = acc_q ^ rx.data_out;
            rx_idx_d     = rx_idx_q + IDX_W'(1);
          end else begin
            // Last read of the packet is the parity byte.
            pkt_done_d    = 1'b1;
            parity_err_d  = (rx.data_out != acc_q);
            addr_err_d    = (addr_q != PORT_ADDR);
            timeout_err_d = 1'b0;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
          end
        end else if (tmo_expire_c) begin
          pkt_done_d    = 1'b1;
          parity_err_d  = 1'b0;
          addr_err_d    = (addr_q != PORT_ADDR);
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cap_q         <= 1'b0;
      busy_q        <= 1'b0;
      hdr_len_q     <= '0;
      addr_q        <= '0;
      acc_q         <= '0;
      remaining_q   <= '0;
      issued_q      <= '0;
      rx_idx_q      <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      pkt_done_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_q         <= rd_issue_c;
      busy_q        <= busy_d;
      hdr_len_q     <= hdr_len_d;
      addr_q        <= addr_d;
      acc_q         <= acc_d;
      remaining_q   <= remaining_d;
      issued_q      <= issued_d;
      rx_idx_q      <= rx_idx_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      pkt_done_q    <= pkt_done_d;
      parity_err_q  <= parity_err_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rx.read_enb    = read_enb_c;
  assign rx.byte_valid  = byte_valid_q;
  assign rx.byte_data   = byte_data_q;
  assign rx.hdr_len     = hdr_len_q;
  assign rx.pkt_done    = pkt_done_q;
  assign rx.parity_err  = parity_err_q;
  assign rx.addr_err    = addr_err_q;
  assign rx.timeout_err = timeout_err_q;
  assign rx.busy        = busy_q;

`ifdef RX_PKT_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating packet and error-packet counters.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pkt_done_d) begin
      if (pkt_cnt_q != '1) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
      if ((parity_err_d || addr_err_d || timeout_err_d) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_rx.sv
// Directed bench for router_pkt_rx: a FIFO model feeds packets, a scoreboard
// holds expected payload bytes and per-packet status.
module tb_router_pkt_rx;

  typedef struct packed {
    logic [5:0] len;
    logic       perr;
    logic       aerr;
    logic       terr;
  } st_t;

  logic clk = 1'b0;
  logic resetn;

  router_pkt_rx_if #(.WIDTH(8)) bus ();

`ifdef RX_PKT_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  router_pkt_rx #(
    .WIDTH     (8),
    .PORT_ADDR (2'd0),
    .TIMEOUT   (30)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .rx     (bus)
`ifdef RX_PKT_STATS_EN
    , .pkt_cnt (pkt_cnt)
    , .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_bytes  = 0;
  int exp_pkts = 0;
  int exp_errs = 0;

  logic [7:0] exp_q[$];
  st_t        st_q[$];
  logic [7:0] pl [0:63];

  // FIFO model: registered read data, one cycle after a granted read.
  logic [7:0]  mem [0:255];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  bit          flush = 1'b0;

  assign bus.valid_out = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.read_enb && bus.valid_out) begin
      bus.data_out <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic send_pkt(input int len, input logic [1:0] addr, input logic [7:0] flip);
    logic [7:0] hdr;
    logic [7:0] par;
    st_t        s;
    hdr = {6'(len), addr};
    par = hdr;
    push(hdr);
    for (int i = 0; i < len; i++) begin
      push(pl[i]);
      exp_q.push_back(pl[i]);
      par = par ^ pl[i];
    end
    push(par ^ flip);
    s.len  = 6'(len);
    s.perr = (flip != 8'h00);
    s.aerr = (addr != 2'd0);
    s.terr = 1'b0;
    st_q.push_back(s);
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    int k = 0;
    while (n_done < target && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("pkt_done_reached", 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int max_cyc);
    int k = 0;
    while (n_bytes < target && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("bytes_reached", 32'(n_bytes >= target), 32'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  logic [7:0] mon_e;
  st_t        mon_s;
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.read_enb) chk("rd_needs_valid", 32'(bus.valid_out), 32'd1);
      if (bus.byte_valid) begin
        chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("byte_data", 32'(bus.byte_data), 32'(mon_e));
        end
        n_bytes++;
      end
      if (bus.pkt_done) begin
        chk("status_expected", 32'(st_q.size() > 0), 32'd1);
        if (st_q.size() > 0) begin
          mon_s = st_q.pop_front();
          chk("hdr_len",     32'(bus.hdr_len),     32'(mon_s.len));
          chk("parity_err",  32'(bus.parity_err),  32'(mon_s.perr));
          chk("addr_err",    32'(bus.addr_err),    32'(mon_s.aerr));
          chk("timeout_err", 32'(bus.timeout_err), 32'(mon_s.terr));
          exp_pkts++;
          if (mon_s.perr || mon_s.aerr || mon_s.terr) exp_errs++;
        end
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        n_done++;
      end
    end
  end

  initial begin
    int base;
    int k;
    resetn         = 1'b0;
    bus.sink_ready = 1'b0;
    bus.data_out   = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_read_enb",   32'(bus.read_enb),    32'd0);
    chk("rst_byte_valid", 32'(bus.byte_valid),  32'd0);
    chk("rst_pkt_done",   32'(bus.pkt_done),    32'd0);
    chk("rst_busy",       32'(bus.busy),        32'd0);
    chk("rst_hdr_len",    32'(bus.hdr_len),     32'd0);
    chk("rst_errs",       32'({bus.parity_err, bus.addr_err, bus.timeout_err}), 32'd0);
    resetn         = 1'b1;
    bus.sink_ready = 1'b1;
    @(negedge clk);

    // Good packet, len 3.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(3, 2'd0, 8'h00);
    wait_done(1, 100);

    // Same packet with corrupted parity; flag must hold until the next packet.
    send_pkt(3, 2'd0, 8'h01);
    wait_done(2, 100);
    @(negedge clk);
    chk("parity_err_hold", 32'(bus.parity_err), 32'd1);

    // Header 0x0D: len 3, address 1.
    send_pkt(3, 2'd1, 8'h00);
    wait_done(3, 100);

    // Sink stall mid-payload.
    for (int i = 0; i < 6; i++) pl[i] = 8'(8'h40 + i);
    base = n_bytes;
    send_pkt(6, 2'd0, 8'h00);
    wait_bytes(base + 2, 100);
    bus.sink_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_no_read", 32'(bus.read_enb), 32'd0);
      @(negedge clk);
    end
    bus.sink_ready = 1'b1;
    wait_done(4, 100);

    // FIFO starves after 2 of 4 body bytes.
    push(8'h10);
    push(8'hA1); exp_q.push_back(8'hA1);
    push(8'hA2); exp_q.push_back(8'hA2);
    st_q.push_back(st_t'{len: 6'd4, perr: 1'b0, aerr: 1'b0, terr: 1'b1});
    k = 0;
    while (rd_ptr != wr_ptr && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("fifo_drained", 32'(rd_ptr == wr_ptr), 32'd1);
    repeat (28) @(negedge clk);
    chk("busy_before_timeout", 32'(bus.busy), 32'd1);
    wait_done(5, 20);
    @(negedge clk);
    chk("idle_after_timeout", 32'(bus.busy), 32'd0);

    // Back-to-back len 0 and len 63.
    for (int i = 0; i < 64; i++) pl[i] = 8'(i * 7 + 3);
    base = n_bytes;
    send_pkt(0, 2'd0, 8'h00);
    send_pkt(63, 2'd0, 8'h00);
    wait_done(6, 50);
    chk("len0_no_bytes", 32'(n_bytes - base), 32'd0);
    wait_done(7, 400);
    chk("len63_bytes", 32'(n_bytes - base), 32'd63);
`ifdef RX_PKT_STATS_EN
    chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
    chk("err_cnt", 32'(err_cnt), 32'(exp_errs));
`endif

    // Async reset mid-payload.
    for (int i = 0; i < 10; i++) pl[i] = 8'(8'hC0 + i);
    base = n_bytes;
    send_pkt(10, 2'd0, 8'h00);
    wait_bytes(base + 3, 100);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_read_enb",   32'(bus.read_enb),   32'd0);
    chk("arst_byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("arst_byte_data",  32'(bus.byte_data),  32'd0);
    chk("arst_hdr_len",    32'(bus.hdr_len),    32'd0);
    chk("arst_busy",       32'(bus.busy),       32'd0);
    chk("arst_flags",      32'({bus.pkt_done, bus.parity_err, bus.addr_err, bus.timeout_err}), 32'd0);
`ifdef RX_PKT_STATS_EN
    chk("arst_pkt_cnt",    32'(pkt_cnt),        32'd0);
`endif
    exp_q.delete();
    st_q.delete();
    exp_pkts = 0;
    exp_errs = 0;
    flush = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    pl[0] = 8'h5A; pl[1] = 8'hC3;
    send_pkt(2, 2'd0, 8'h00);
    wait_done(n_done + 1, 100);
`ifdef RX_PKT_STATS_EN
    chk("pkt_cnt_after_rst", 32'(pkt_cnt), 32'(exp_pkts));
`endif

    repeat (3) @(negedge clk);
    chk("bytes_all_seen",  32'(exp_q.size()), 32'd0);
    chk("status_all_seen", 32'(st_q.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
